// File: rtl/cpu_defs.sv
// Shared opcode, IR field and sequencer state definitions for the 32-bit bus datapath.
// Combinational helpers only; no latency and no flow control.
package cpu_defs;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 23;
    localparam int RB_MSB     = 22;
    localparam int RB_LSB     = 19;
    localparam int RC_MSB     = 18;
    localparam int RC_LSB     = 15;

    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MULDIV, CLS_IMM, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } instr_class_e;

    function automatic instr_class_e classify(input logic [4:0] op);
        instr_class_e cls;
        cls = CLS_ILLEGAL;
        if (op >= OP_ADD && op <= OP_SHL)                      cls = CLS_ALU;
        else if (op == OP_MUL || op == OP_DIV)                 cls = CLS_MULDIV;
        else if ((op >= OP_ADDI && op <= OP_ORI) || op == OP_LDI) cls = CLS_IMM;
        else if (op == OP_NEG || op == OP_NOT)                 cls = CLS_UNARY;
        else if (op == OP_NOP)                                 cls = CLS_NOP;
        else if (op == OP_HALT)                                cls = CLS_HALT;
        return cls;
    endfunction

    // Immediate forms reuse the matching register-form ALU operation.
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        logic [4:0] alu_op;
        case (op)
            OP_ANDI: alu_op = OP_AND;
            OP_ORI:  alu_op = OP_OR;
            default: alu_op = OP_ADD;
        endcase
        return alu_op;
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// 4-bit register field plus enable to a one-hot register select; fields >= NUM_REGS give zero.
// Purely combinational; no backpressure.
module reg_field_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          field_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en_i && (int'(field_i) == i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Moore control unit: fetch T0-T2, decode on IR, execute T3-T6; outputs decode from state and ir.
// Instruction takes 4-7 cycles plus MEM_WAIT; run only gates the next fetch, HALT exits only via clear.
module alu_control_sequencer
    import cpu_defs::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int NUM_REGS = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
    output logic [NUM_REGS-1:0] rin,
    output logic [NUM_REGS-1:0] rout,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zhighin,
    output logic                Zlowin,
    output logic                ZHIout,
    output logic                ZLOout,
    output logic                HIin,
    output logic                LOin,
    output logic                Cout,
    output logic                read,
    output logic [4:0]          operation,
    output logic                instr_done,
    output logic                halted,
    output logic                illegal
);

    localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;

    logic [4:0]   op;
    logic [3:0]   ra, rb, rc;
    instr_class_e cls;
    logic         rin_en, rout_en;
    logic [3:0]   rin_sel, rout_sel;

    assign op  = ir[OPCODE_MSB:OPCODE_LSB];
    assign ra  = ir[RA_MSB:RA_LSB];
    assign rb  = ir[RB_MSB:RB_LSB];
    assign rc  = ir[RC_MSB:RC_LSB];
    assign cls = classify(op);

    // Immediate/offset bits are consumed by the datapath through Cout, not here.
    logic unused_imm_bits;
    assign unused_imm_bits = ^ir[RC_LSB-1:0];

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        rin_en     = 1'b0;
        rin_sel    = ra;
        rout_en    = 1'b0;
        rout_sel   = rb;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zhighin    = 1'b0;
        Zlowin     = 1'b0;
        ZHIout     = 1'b0;
        ZLOout     = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Cout       = 1'b0;
        read       = 1'b0;
        operation  = 5'b00000;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (state_q)
            IDLE: if (run) state_d = T0;
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                state_d = T1;
            end
            T1: begin
                read  = 1'b1;
                MDRin = 1'b1;
                // The incremented PC is written back once, not on every wait cycle.
                if (wait_q == '0) begin
                    ZLOout = 1'b1;
                    PCin   = 1'b1;
                end
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = T2;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                case (cls)
                    CLS_ALU, CLS_MULDIV, CLS_IMM: begin
                        rout_en = 1'b1;
                        Yin     = 1'b1;
                        state_d = T4;
                    end
                    CLS_UNARY: begin
                        rout_en   = 1'b1;
                        operation = op;
                        Zlowin    = 1'b1;
                        state_d   = T4;
                    end
                    CLS_NOP:  instr_done = 1'b1;
                    CLS_HALT: state_d = HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT;
                    end
                endcase
            end
            T4: begin
                state_d = T5;
                case (cls)
                    CLS_ALU, CLS_MULDIV: begin
                        rout_en   = 1'b1;
                        rout_sel  = rc;
                        operation = op;
                        Zlowin    = 1'b1;
                        Zhighin   = (cls == CLS_MULDIV);
                    end
                    CLS_IMM: begin
                        Cout      = 1'b1;
                        Zlowin    = 1'b1;
                        operation = imm_alu_op(op);
                    end
                    CLS_UNARY: begin
                        ZLOout     = 1'b1;
                        rin_en     = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
            T5: begin
                case (cls)
                    CLS_MULDIV: begin
                        ZLOout  = 1'b1;
                        LOin    = 1'b1;
                        state_d = T6;
                    end
                    CLS_ALU, CLS_IMM: begin
                        ZLOout     = 1'b1;
                        rin_en     = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
            T6: begin
                ZHIout     = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: state_d = IDLE;
        endcase

        if (instr_done) begin
            state_d = run ? T0 : IDLE;
        end
    end

    assign illegal = illegal_q;

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .field_i  (rin_sel),
        .en_i     (rin_en),
        .onehot_o (rin)
    );

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .field_i  (rout_sel),
        .en_i     (rout_en),
        .onehot_o (rout)
    );

    a_single_bus_driver: assert property (@(posedge clock) disable iff (clear)
        $onehot0({PCout, MDRout, ZLOout, ZHIout, Cout, |rout}));

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: directed table, MEM_WAIT=2 sequence, randomized run against a cycle-index model.
module tb_alu_control_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [15:0] en;
        logic [4:0]  op;
        logic        done;
        logic        halted;
        logic        illegal;
    } outs_t;

    typedef struct {
        logic        clr;
        logic        rn;
        logic [31:0] ir;
        outs_t       exp;
    } vec_t;

    localparam logic [15:0] E_PCOUT = 16'h8000, E_PCIN = 16'h4000, E_INCPC = 16'h2000;
    localparam logic [15:0] E_MARIN = 16'h1000, E_MDRIN = 16'h0800, E_MDROUT = 16'h0400;
    localparam logic [15:0] E_IRIN = 16'h0200, E_YIN = 16'h0100, E_ZHIGHIN = 16'h0080;
    localparam logic [15:0] E_ZLOWIN = 16'h0040, E_ZHIOUT = 16'h0020, E_ZLOOUT = 16'h0010;
    localparam logic [15:0] E_HIIN = 16'h0008, E_LOIN = 16'h0004, E_COUT = 16'h0002, E_READ = 16'h0001;

    localparam int M_IDLE = 0, M_BUSY = 1, M_HALT = 2;

    int wv[2] = '{0, 2};
    int nr[2] = '{16, 8};
    int mode_m[2];
    int c_m[2];
    logic ill_m[2];

    logic [4:0] valid_ops [18] = '{5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                   5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26};
    logic [4:0] bad_ops [14] = '{5'd0, 5'd2, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25,
                                 5'd28, 5'd29, 5'd30, 5'd31, 5'd31};

    logic        clock = 1'b0;
    logic        clear, run;
    logic [31:0] ir0, ir2;
    logic [15:0] rin0, rout0, en0;
    logic [7:0]  rin2, rout2;
    logic [15:0] en2;
    logic [4:0]  op0, op2;
    logic        done0, done2, halted0, halted2, ill0, ill2;
    outs_t       got0, got2;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clock = ~clock;

    alu_control_sequencer #(.MEM_WAIT(0), .NUM_REGS(16)) dut0 (
        .clock(clock), .clear(clear), .run(run), .ir(ir0), .rin(rin0), .rout(rout0),
        .PCout(en0[15]), .PCin(en0[14]), .IncPC(en0[13]), .MARin(en0[12]), .MDRin(en0[11]),
        .MDRout(en0[10]), .IRin(en0[9]), .Yin(en0[8]), .Zhighin(en0[7]), .Zlowin(en0[6]),
        .ZHIout(en0[5]), .ZLOout(en0[4]), .HIin(en0[3]), .LOin(en0[2]), .Cout(en0[1]),
        .read(en0[0]), .operation(op0), .instr_done(done0), .halted(halted0), .illegal(ill0)
    );

    alu_control_sequencer #(.MEM_WAIT(2), .NUM_REGS(8)) dut2 (
        .clock(clock), .clear(clear), .run(run), .ir(ir2), .rin(rin2), .rout(rout2),
        .PCout(en2[15]), .PCin(en2[14]), .IncPC(en2[13]), .MARin(en2[12]), .MDRin(en2[11]),
        .MDRout(en2[10]), .IRin(en2[9]), .Yin(en2[8]), .Zhighin(en2[7]), .Zlowin(en2[6]),
        .ZHIout(en2[5]), .ZLOout(en2[4]), .HIin(en2[3]), .LOin(en2[2]), .Cout(en2[1]),
        .read(en2[0]), .operation(op2), .instr_done(done2), .halted(halted2), .illegal(ill2)
    );

    always_comb begin
        got0 = '0;
        got0.rin = rin0;  got0.rout = rout0; got0.en = en0; got0.op = op0;
        got0.done = done0; got0.halted = halted0; got0.illegal = ill0;
        got2 = '0;
        got2.rin = {8'h00, rin2}; got2.rout = {8'h00, rout2}; got2.en = en2; got2.op = op2;
        got2.done = done2; got2.halted = halted2; got2.illegal = ill2;
    end

    function automatic outs_t mk(logic [15:0] ri, logic [15:0] ro, logic [15:0] en,
                                 logic [4:0] op, logic dn);
        outs_t o = '0;
        o.rin = ri; o.rout = ro; o.en = en; o.op = op; o.done = dn;
        return o;
    endfunction

    function automatic logic [15:0] oh(logic [3:0] f, int n);
        logic [15:0] v = '0;
        if (int'(f) < n) v[f] = 1'b1;
        return v;
    endfunction

    // 0 alu, 1 mul/div, 2 immediate, 3 unary, 4 nop, 5 halt, 6 illegal
    function automatic int kind(logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 0;
        if (op == 5'd15 || op == 5'd16) return 1;
        if ((op >= 5'd12 && op <= 5'd14) || op == 5'd1) return 2;
        if (op == 5'd17 || op == 5'd18) return 3;
        if (op == 5'd26) return 4;
        if (op == 5'd27) return 5;
        return 6;
    endfunction

    function automatic int exec_len(logic [4:0] op);
        int lens[7] = '{3, 4, 3, 2, 1, 1, 1};
        return lens[kind(op)];
    endfunction

    function automatic outs_t exec_out(int e, logic [31:0] w, int n);
        logic [4:0] op = w[31:27];
        logic [15:0] ra = oh(w[26:23], n), rb = oh(w[22:19], n), rc = oh(w[18:15], n);
        logic [4:0] iop = (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3;
        case (kind(op))
            0: case (e)
                0: return mk(0, rb, E_YIN, 0, 0);
                1: return mk(0, rc, E_ZLOWIN, op, 0);
                default: return mk(ra, 0, E_ZLOOUT, 0, 1);
            endcase
            1: case (e)
                0: return mk(0, rb, E_YIN, 0, 0);
                1: return mk(0, rc, E_ZLOWIN | E_ZHIGHIN, op, 0);
                2: return mk(0, 0, E_ZLOOUT | E_LOIN, 0, 0);
                default: return mk(0, 0, E_ZHIOUT | E_HIIN, 0, 1);
            endcase
            2: case (e)
                0: return mk(0, rb, E_YIN, 0, 0);
                1: return mk(0, 0, E_COUT | E_ZLOWIN, iop, 0);
                default: return mk(ra, 0, E_ZLOOUT, 0, 1);
            endcase
            3: if (e == 0) return mk(0, rb, E_ZLOWIN, op, 0);
               else return mk(ra, 0, E_ZLOOUT, 0, 1);
            4: return mk(0, 0, 0, 0, 1);
            default: return '0;
        endcase
    endfunction

    // Expected outputs from (mode, cycle index within the instruction, current ir).
    function automatic outs_t model_out(int k, logic [31:0] w);
        outs_t o = '0;
        int c = c_m[k];
        int wt = wv[k];
        if (mode_m[k] == M_HALT) o.halted = 1'b1;
        else if (mode_m[k] == M_BUSY) begin
            if (c == 0) o.en = E_PCOUT | E_MARIN | E_INCPC | E_ZLOWIN;
            else if (c == 1) o.en = E_ZLOOUT | E_PCIN | E_READ | E_MDRIN;
            else if (c <= wt + 1) o.en = E_READ | E_MDRIN;
            else if (c == wt + 2) o.en = E_MDROUT | E_IRIN;
            else o = exec_out(c - wt - 3, w, nr[k]);
        end
        o.illegal = ill_m[k];
        return o;
    endfunction

    task automatic model_step(int k, logic [31:0] w);
        int xs = wv[k] + 3;
        if (clear) begin
            mode_m[k] = M_IDLE; c_m[k] = 0; ill_m[k] = 1'b0;
        end else if (mode_m[k] == M_IDLE) begin
            if (run) begin mode_m[k] = M_BUSY; c_m[k] = 0; end
        end else if (mode_m[k] == M_BUSY) begin
            if (c_m[k] >= xs && c_m[k] - xs == exec_len(w[31:27]) - 1) begin
                if (kind(w[31:27]) == 5) mode_m[k] = M_HALT;
                else if (kind(w[31:27]) == 6) begin mode_m[k] = M_HALT; ill_m[k] = 1'b1; end
                else if (run) c_m[k] = 0;
                else mode_m[k] = M_IDLE;
            end else begin
                c_m[k]++;
            end
        end
    endtask

    task automatic check_model(int k, outs_t g, logic [31:0] w);
        outs_t e = model_out(k, w);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL model dut%0d cycle %0d got %h exp %h", k, cycle, g, e);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int sel = $urandom_range(0, 39);
        logic [4:0] op;
        if (sel < 2) op = bad_ops[$urandom_range(0, 13)];
        else if (sel == 2) op = 5'd27;
        else op = valid_ops[$urandom_range(0, 17)];
        return {op, 27'($urandom)};
    endfunction

    task automatic step(input logic clr, input logic rn, input logic [31:0] i0,
                        input logic [31:0] i2, input bit rnd);
        @(negedge clock);
        clear = clr;
        run   = rn;
        if (rnd) begin
            if (mode_m[0] == M_BUSY && c_m[0] == 3) ir0 = rand_instr();
            if (mode_m[1] == M_BUSY && c_m[1] == 5) ir2 = rand_instr();
        end else begin
            ir0 = i0;
            ir2 = i2;
        end
        #1;
        cycle++;
        check_model(0, got0, ir0);
        check_model(1, got2, ir2);
        model_step(0, ir0);
        model_step(1, ir2);
    endtask

    task automatic expect_eq(string name, logic [31:0] g, logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, g, e);
        end
    endtask

    initial begin
        logic [31:0] IR_OR, IR_MUL, IR_BAD, IR_ADD, IR_ADDI2;
        outs_t t0, t1, t2, hz;
        vec_t vec[33];
        int reads, pcins, pcin_at, done_at, halt_cnt;

        IR_OR    = 32'h30918000;
        IR_MUL   = {5'b01111, 4'd5, 4'd3, 4'd4, 15'd0};
        IR_BAD   = {5'b11111, 27'd0};
        IR_ADD   = {5'b00011, 4'd7, 4'd1, 4'd2, 15'd0};
        IR_ADDI2 = {5'b01100, 4'd2, 4'd9, 4'd0, 15'h1234};
        t0 = mk(0, 0, E_PCOUT | E_MARIN | E_INCPC | E_ZLOWIN, 0, 0);
        t1 = mk(0, 0, E_ZLOOUT | E_PCIN | E_READ | E_MDRIN, 0, 0);
        t2 = mk(0, 0, E_MDROUT | E_IRIN, 0, 0);
        hz = '0; hz.halted = 1'b1; hz.illegal = 1'b1;

        vec[0]  = '{1, 1, IR_OR, '0};
        vec[1]  = '{0, 1, IR_OR, '0};
        vec[2]  = '{0, 1, IR_OR, t0};
        vec[3]  = '{0, 1, IR_OR, t1};
        vec[4]  = '{0, 1, IR_OR, t2};
        vec[5]  = '{0, 1, IR_OR, mk(0, 16'h0004, E_YIN, 0, 0)};
        vec[6]  = '{0, 1, IR_OR, mk(0, 16'h0008, E_ZLOWIN, 5'b00110, 0)};
        vec[7]  = '{0, 0, IR_OR, mk(16'h0002, 0, E_ZLOOUT, 0, 1)};
        vec[8]  = '{0, 1, IR_MUL, '0};
        vec[9]  = '{0, 1, IR_MUL, t0};
        vec[10] = '{0, 1, IR_MUL, t1};
        vec[11] = '{0, 1, IR_MUL, t2};
        vec[12] = '{0, 1, IR_MUL, mk(0, 16'h0008, E_YIN, 0, 0)};
        vec[13] = '{0, 1, IR_MUL, mk(0, 16'h0010, E_ZLOWIN | E_ZHIGHIN, 5'b01111, 0)};
        vec[14] = '{0, 1, IR_MUL, mk(0, 0, E_ZLOOUT | E_LOIN, 0, 0)};
        vec[15] = '{0, 1, IR_MUL, mk(0, 0, E_ZHIOUT | E_HIIN, 0, 1)};
        vec[16] = '{0, 1, IR_BAD, t0};
        vec[17] = '{0, 1, IR_BAD, t1};
        vec[18] = '{0, 1, IR_BAD, t2};
        vec[19] = '{0, 1, IR_BAD, '0};
        vec[20] = '{0, 1, IR_BAD, hz};
        vec[21] = '{0, 1, IR_BAD, hz};
        vec[22] = '{1, 1, IR_BAD, hz};
        vec[23] = '{0, 0, IR_ADD, '0};
        vec[24] = '{0, 1, IR_ADD, '0};
        vec[25] = '{0, 1, IR_ADD, t0};
        vec[26] = '{0, 1, IR_ADD, t1};
        vec[27] = '{0, 1, IR_ADD, t2};
        vec[28] = '{0, 1, IR_ADD, mk(0, 16'h0002, E_YIN, 0, 0)};
        vec[29] = '{0, 0, IR_ADD, mk(0, 16'h0004, E_ZLOWIN, 5'b00011, 0)};
        vec[30] = '{0, 0, IR_ADD, mk(16'h0080, 0, E_ZLOOUT, 0, 1)};
        vec[31] = '{0, 1, IR_ADD, '0};
        vec[32] = '{0, 1, IR_ADD, t0};

        for (int k = 0; k < 2; k++) begin
            mode_m[k] = M_IDLE; c_m[k] = 0; ill_m[k] = 1'b0;
        end
        clear = 1'b1; run = 1'b0; ir0 = '0; ir2 = '0;
        @(posedge clock);

        for (int i = 0; i < 33; i++) begin
            step(vec[i].clr, vec[i].rn, vec[i].ir, IR_ADDI2, 1'b0);
            checks++;
            if (got0 !== vec[i].exp) begin
                errors++;
                $display("FAIL table row %0d got %h exp %h", i, got0, vec[i].exp);
            end
        end

        // MEM_WAIT=2 addi with rb beyond the 8-register file.
        step(1'b1, 1'b0, IR_OR, IR_ADDI2, 1'b0);
        step(1'b0, 1'b1, IR_OR, IR_ADDI2, 1'b0);
        reads = 0; pcins = 0; pcin_at = -1; done_at = -1;
        for (int n = 1; n <= 10; n++) begin
            step(1'b0, 1'b0, IR_OR, IR_ADDI2, 1'b0);
            if (en2[0]) reads++;
            if (en2[14]) begin pcins++; if (pcin_at < 0) pcin_at = n; end
            if (done2 && done_at < 0) done_at = n;
            if (n == 6) expect_eq("addi_w2_t3_rout", {24'h0, rout2}, 32'h0);
            if (n == 7) expect_eq("addi_w2_t4_cout_op", {26'h0, en2[1], op2}, {26'h0, 1'b1, 5'b00011});
            if (n == 8) expect_eq("addi_w2_t5_rin", {24'h0, rin2}, 32'h04);
        end
        expect_eq("addi_w2_read_cycles", reads, 3);
        expect_eq("addi_w2_pcin_cycles", pcins, 1);
        expect_eq("addi_w2_pcin_first_t1", pcin_at, 2);
        expect_eq("addi_w2_done_cycle", done_at, 8);

        halt_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            logic clr;
            clr = (halt_cnt > 5) || ($urandom_range(0, 199) == 0);
            if (clr) halt_cnt = 0;
            else if (mode_m[0] == M_HALT || mode_m[1] == M_HALT) halt_cnt++;
            step(clr, $urandom_range(0, 7) != 0, '0, '0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Moore-style control unit for the bus-based 32-bit datapath.
- Replaces hand-driven testbench control with hardware sequencing. Each instruction runs through fetch (T0–T2), decode on the IR contents, and execute (T3–T6).
- Drives every bus in/out enable, the ALU operation code and the memory read strobe.
- Scope: ALU register, immediate, mul/div, unary, ldi, nop and halt. Load/store decode as illegal until the memory path exists.

Parameters:
MEM_WAIT, 0, extra cycles T1 holds read/MDRin before advancing (0 = single-cycle memory)
NUM_REGS, 16, general registers; width of rin/rout one-hot vectors

Ports:
clock  in  1  system clock, all state changes on rising edge
clear  in  1  synchronous active-high reset
run  in  1  level; 1 = fetch next instruction, 0 = stall in IDLE at instruction boundary
ir  in  32  IR register contents; opcode[31:27], ra[26:23], rb[22:19], rc[18:15]
rin  out  NUM_REGS  one-hot general-register load enables
rout  out  NUM_REGS  one-hot general-register bus drive enables
PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin  out  1  datapath enables
Zhighin, Zlowin, ZHIout, ZLOout, HIin, LOin, Cout  out  1  datapath enables
read  out  1  memory read strobe
operation  out  5  ALU op code
instr_done  out  1  one-cycle pulse in final execute cycle
halted  out  1  high in HALT state
illegal  out  1  sticky; set on unsupported opcode, cleared only by clear

Behaviour:
- Reset: clear=1 at a rising edge forces state IDLE, clears illegal, and clears the wait counter, including mid-instruction.
- Reset output values: all outputs 0, operation=5'b00000.
- Outputs are a pure function of the registered state plus ir fields. Each enable is asserted for the whole cycle.
- At most one bus driver is high in any cycle; assert this in simulation.
- IDLE: all outputs 0. Go to T0 when run=1, else stay.
- T0: PCout, MARin, IncPC, Zlowin -> T1.
- T1: ZLOout, PCin, read, MDRin.
  - read and MDRin hold for MEM_WAIT extra cycles via a counter.
  - ZLOout and PCin are asserted only in the first T1 cycle.
  - Then -> T2.
- T2: MDRout, IRin -> T3. IR is loaded at the end of T2; decode uses ir from T3 on.
- T3 decode, by opcode:
  - 3-reg ALU, 00011–01011 (add, sub, and, or, ror, rol, shr, shra, shl) and mul/div 01111–10000:
    - T3: rout[rb], Yin.
    - T4: rout[rc], operation=opcode. Zlowin, plus Zhighin for mul/div.
    - T5: ZLOout, then either rin[ra] (ALU), or LOin (mul/div).
    - T6, mul/div only: ZHIout, HIin.
  - Immediate, addi/andi/ori 01100–01110:
    - T3: rout[rb], Yin.
    - T4: Cout, Zlowin. operation = 00011 / 00101 / 00110 respectively.
    - T5: ZLOout, rin[ra].
  - ldi 00001: same as addi.
  - Unary, neg/not 10001–10010:
    - T3: rout[rb], operation=opcode, Zlowin.
    - T4: ZLOout, rin[ra].
  - nop 11010: instr_done in T3, then next fetch.
  - halt 11011: -> HALT.
  - Any other opcode: set illegal, -> HALT.
- instr_done pulses in the last execute state. Next state is T0 if run=1, else IDLE.
- HALT: halted=1, all enables 0. Exit only via clear.
- rin/rout are decoded from 4-bit fields as one-hot. A field >= NUM_REGS decodes to all-zero.
- Cycle counts from T0 to instr_done (MEM_WAIT=0):
  - nop: 4.
  - Unary: 5.
  - 3-reg ALU and immediate: 6.
  - mul/div: 7.
  - Each MEM_WAIT cycle adds 1.
- run falling mid-instruction: the instruction completes, then IDLE.

Decomposition:
- Shared package `cpu_defs`:
  - opcode localparams (OP_ADD=5'b00011 … OP_HALT=5'b11011);
  - field bit positions;
  - state encoding enum (IDLE, T0–T6, HALT).
- One sub-module, `reg_field_decoder`: 4-bit field plus enable -> NUM_REGS one-hot. It is instantiated twice, once for rin and once for rout.

Test Plan:
- clear=1 for 2 cycles, run=1 -> all outputs 0 during clear. T0 asserts PCout, MARin, IncPC and Zlowin on the first cycle after clear drops.
- ir=32'h30918000 (or R1,R2,R3) -> T3 rout=16'h0004 + Yin; T4 rout=16'h0008, operation=5'b00110, Zlowin; T5 ZLOout, rin=16'h0002; instr_done at cycle 6.
- ir opcode 01111 (mul), rb=R3, rc=R4 -> T4 Zlowin & Zhighin; T5 ZLOout+LOin; T6 ZHIout+HIin, instr_done at cycle 7.
- MEM_WAIT=2, addi -> read held 3 cycles in T1; PCin high only in the first; instr_done at cycle 8.
- opcode 11111 -> illegal=1 and halted=1 from the next cycle, run ignored. A clear pulse returns to IDLE with illegal=0.
- run dropped during T4 of add -> instruction completes (rin[ra] in T5), then IDLE. Reassert run -> T0 next cycle.
